dram_write_scatter: RTL
=======================

# dram_write_scatter

Write-back path of the DMA pipeline. Accepts VSIZE-word vectors read from local SRAM and scatters them into CSIZE-word DRAM lines under per-chunk commands (offset, length). It emits each completed line with a per-word write mask on a rdy/ack port toward the DRAM write channel. It is the mirror of the DRAM-read-to-SRAM collector and shares its command format and TauCfg sizing.

## Interface
- LBW, TauCfg::LOCAL_ADDR_BW0, local address width; transfer size is LBW+1 bits.
- DBW, TauCfg::DATA_BW, word width.
- VSIZE, TauCfg::VSIZE, words per SRAM vector; CV_BW1 = $clog2(VSIZE+1).
- CSIZE, TauCfg::CACHE_SIZE, words per DRAM line; CC_BW = $clog2(CSIZE).
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- alloc_rdy / alloc_ack  in / out  1  transfer start handshake.
- i_size  in  LBW+1  total words in the transfer.
- sramrd_rdy / sramrd_ack  in / out  1  SRAM vector handshake.
- i_sramrd  in  DBW x VSIZE  SRAM vector; word 0 comes first.
- cmd_rdy / cmd_ack  in / out  1  chunk command handshake.
- i_cmd_addrofs  in  CC_BW  first line word written by this chunk.
- i_cmd_len  in  CV_BW1  chunk length, 1..VSIZE; addrofs+len <= CSIZE.
- i_cmd_islast  in  1  chunk closes the current DRAM line.
- dramwr_rdy / dramwr_ack  out / in  1  line output handshake.
- o_dramwr  out  DBW x CSIZE  line data (registered).
- o_dramwr_mask  out  CSIZE  per-word write enable (registered).

## Operation
- One-hot FSM with states FREE, RUN, SEND.
- FREE:
  - alloc_ack = alloc_rdy.
  - On ack, latch size_r = i_size and clear sent_r, vec_r and cmd_handled_r.
  - Go to RUN, or stay in FREE if i_size == 0.
- RUN step fires when cmd_rdy && sramrd_rdy:
  - vec_left = VSIZE - vec_r; cmd_left = i_cmd_len - cmd_handled_r; n = min(vec_left, cmd_left).
  - For k < n: line[i_cmd_addrofs + cmd_handled_r + k] = i_sramrd[vec_r + k], and the matching mask bit is set.
  - sent_r += n.
  - cmd_ack when n == cmd_left. cmd_handled_r clears on ack, otherwise += n.
  - sramrd_ack when n == vec_left or sent_r + n == size_r. vec_r clears on ack, otherwise += n.
  - If cmd_ack && i_cmd_islast, go to SEND; otherwise stay in RUN.
- SEND:
  - dramwr_rdy = 1.
  - On dramwr_ack, clear the mask. Go to FREE if sent_r == size_r, else to RUN.
  - Line data need not be cleared; masked-off words are don't-care.
- Width rules:
  - sent_r is LBW+1 bits and compared for equality only.
  - Offset arithmetic is CC_BW+1 bits wide and never wraps, because of the addrofs+len bound.
- Illegal input: total reached while the command is not islast is a protocol error. Behaviour is unspecified, and the testbench asserts on it.

## Timing
- Reset values:
  - fsm = FREE; every ack = 0; dramwr_rdy = 0.
  - o_dramwr = 0; o_dramwr_mask = 0; all counters 0.
- Every ack is combinational in the cycle of its step and depends on the rdy inputs of that cycle.
- At most one merge step per cycle. No step fires in SEND, so cmd_ack and sramrd_ack are 0 throughout SEND.
- Latency: dramwr_rdy rises the cycle after the step that acks the islast command. It holds, with data and mask stable, until dramwr_ack.
- The first RUN step can fire the cycle after dramwr_ack.
- After alloc_ack, the first step can fire the next cycle.
- sramrd_ack and cmd_ack may assert in the same cycle.
- Reset asserted mid-transfer, including in SEND: all outputs return to their reset values immediately, and partial line content is discarded.

## Test plan
All scenarios use VSIZE=4, CSIZE=8, DBW=8.
- **Single chunk, single vector.** size=4; cmd ofs=2 len=4 islast; vector [A,B,C,D].
  -> sramrd_ack and cmd_ack in the same cycle.
  -> Next cycle dramwr_rdy=1, words 2..5 = A..D, mask=8'b00111100.
  -> After dramwr_ack, FSM is FREE.
- **Chunk spanning two vectors.** size=6; cmd ofs=0 len=6 islast; vectors [0,1,2,3] and [4,5,x,x].
  -> Step 1: sramrd_ack only.
  -> Step 2: both acks.
  -> Line = 0..5, mask=8'h3F.
- **Vector spanning two lines.** size=4; cmd ofs=6 len=2 islast, then cmd ofs=0 len=2 islast; vector [P,Q,R,S].
  -> Beat 1: mask=8'hC0, words 6,7 = P,Q.
  -> Beat 2: mask=8'h03, words 0,1 = R,S.
  -> sramrd_ack only on the second step.
- **Backpressure.** Hold dramwr_ack low for 5 cycles in SEND.
  -> Data and mask are stable; no cmd_ack or sramrd_ack despite rdy.
  -> Ack on cycle 6 resumes RUN.
- **Zero size.** alloc with size=0.
  -> alloc_ack=1; FSM stays FREE; no other ack ever asserts.
- **Reset in SEND.** Drop i_rst while dramwr_rdy=1.
  -> dramwr_rdy=0 and mask=0 asynchronously.
  -> After release, a new alloc runs scenario 1 correctly.

Source files
------------

// File: rtl/dram_write_scatter.sv
// Write-back scatter: merges SRAM vectors into DRAM lines under (offset, length) chunk
// commands and emits each finished line with a per-word write mask.
module dram_write_scatter #(
    parameter int unsigned LBW    = 10,
    parameter int unsigned DBW    = 8,
    parameter int unsigned VSIZE  = 4,
    parameter int unsigned CSIZE  = 8,
    localparam int unsigned CV_BW1 = $clog2(VSIZE + 1),
    localparam int unsigned CC_BW  = $clog2(CSIZE)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   alloc_rdy,
    output logic                   alloc_ack,
    input  logic [LBW:0]           i_size,
    input  logic                   sramrd_rdy,
    output logic                   sramrd_ack,
    input  logic [VSIZE*DBW-1:0]   i_sramrd,
    input  logic                   cmd_rdy,
    output logic                   cmd_ack,
    input  logic [CC_BW-1:0]       i_cmd_addrofs,
    input  logic [CV_BW1-1:0]      i_cmd_len,
    input  logic                   i_cmd_islast,
    output logic                   dramwr_rdy,
    input  logic                   dramwr_ack,
    output logic [CSIZE*DBW-1:0]   o_dramwr,
    output logic [CSIZE-1:0]       o_dramwr_mask
);

    localparam int unsigned VI_BW = (VSIZE > 1) ? $clog2(VSIZE) : 1;

    typedef enum logic [2:0] {
        StFree = 3'b001,
        StRun  = 3'b010,
        StSend = 3'b100
    } state_t;

    state_t                       state_r;
    logic [LBW:0]                 size_r;
    logic [LBW:0]                 sent_r;
    logic [CV_BW1-1:0]            vec_r;
    logic [CV_BW1-1:0]            cmd_handled_r;
    logic [CSIZE-1:0][DBW-1:0]    line_r;
    logic [CSIZE-1:0]             mask_r;

    logic [VSIZE-1:0][DBW-1:0]    vec_words;
    logic [CV_BW1-1:0]            vec_left;
    logic [CV_BW1-1:0]            cmd_left;
    logic [CV_BW1-1:0]            n;
    logic [LBW:0]                 sent_nx;
    logic                         step;
    logic [CC_BW:0]               dst_idx [VSIZE];
    logic [CV_BW1-1:0]            src_idx [VSIZE];

    assign vec_words = i_sramrd;

    always_comb begin
        vec_left   = CV_BW1'(VSIZE) - vec_r;
        cmd_left   = i_cmd_len - cmd_handled_r;
        n          = (vec_left < cmd_left) ? vec_left : cmd_left;
        sent_nx    = sent_r + (LBW + 1)'(n);
        step       = (state_r == StRun) && cmd_rdy && sramrd_rdy;
        alloc_ack  = (state_r == StFree) && alloc_rdy;
        cmd_ack    = step && (n == cmd_left);
        sramrd_ack = step && ((n == vec_left) || (sent_nx == size_r));
        dramwr_rdy = (state_r == StSend);
    end

    // The addrofs+len bound keeps every live destination below CSIZE, so no wrap handling.
    always_comb begin
        for (int k = 0; k < VSIZE; k++) begin
            dst_idx[k] = {1'b0, i_cmd_addrofs} + (CC_BW + 1)'(cmd_handled_r) + (CC_BW + 1)'(k);
            src_idx[k] = vec_r + CV_BW1'(k);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r       <= StFree;
            size_r        <= '0;
            sent_r        <= '0;
            vec_r         <= '0;
            cmd_handled_r <= '0;
            line_r        <= '0;
            mask_r        <= '0;
        end else begin
            unique case (state_r)
                StFree: begin
                    if (alloc_rdy) begin
                        size_r        <= i_size;
                        sent_r        <= '0;
                        vec_r         <= '0;
                        cmd_handled_r <= '0;
                        if (i_size != '0) state_r <= StRun;
                    end
                end
                StRun: begin
                    if (step) begin
                        for (int k = 0; k < VSIZE; k++) begin
                            if (k < int'(n)) begin
                                line_r[dst_idx[k][CC_BW-1:0]] <= vec_words[src_idx[k][VI_BW-1:0]];
                                mask_r[dst_idx[k][CC_BW-1:0]] <= 1'b1;
                            end
                        end
                        sent_r        <= sent_nx;
                        cmd_handled_r <= cmd_ack ? '0 : cmd_handled_r + n;
                        vec_r         <= sramrd_ack ? '0 : vec_r + n;
                        if (cmd_ack && i_cmd_islast) state_r <= StSend;
                    end
                end
                StSend: begin
                    if (dramwr_ack) begin
                        mask_r  <= '0;
                        state_r <= (sent_r == size_r) ? StFree : StRun;
                    end
                end
                default: state_r <= StFree;
            endcase
        end
    end

    assign o_dramwr      = line_r;
    assign o_dramwr_mask = mask_r;

endmodule
